alu_issue_stage: RTL

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage_pkg.sv | 39 +++
 rtl/alu_issue_stage_alu_op_decode.sv | 34 +++
 rtl/alu_issue_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and types for the ALU issue stage and the existing ALU.
// Operation codes, main-control classes, R-type funct values and skid-buffer types.
package alu_issue_stage_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } skid_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic [3:0]        operation;
        logic              illegal;
    } issue_entry_t;

endpackage

// File: rtl/alu_issue_stage_alu_op_decode.sv
// Combinational main-control class / funct decode into an ALU operation code.
// Unknown R-type funct falls back to ADD and raises illegal.
module alu_op_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] operation,
    output logic       illegal
);

    always_comb begin
        operation = ALU_ADD;
        illegal   = 1'b0;
        case (alu_op)
            ALUOP_ADD: operation = ALU_ADD;
            ALUOP_SUB: operation = ALU_SUB;
            ALUOP_OR:  operation = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: operation = ALU_ADD;
                    FUNCT_SUB: operation = ALU_SUB;
                    FUNCT_AND: operation = ALU_AND;
                    FUNCT_OR:  operation = ALU_OR;
                    FUNCT_SLT: operation = ALU_SLT;
                    FUNCT_NOR: operation = ALU_NOR;
                    default:   illegal   = 1'b1;
                endcase
            end
            default: operation = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes and selects operands at acceptance, then buffers
// issues in a 2-entry skid buffer so in_ready depends only on registered state.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] in1,
    output logic [DATA_W-1:0] in2,
    output logic [3:0]        operation,
    output logic              illegal,
    output logic [15:0]       issued_count
);

    skid_state_e  r_state;
    skid_state_e  w_state_nxt;
    issue_entry_t r_out;
    issue_entry_t r_skid;
    issue_entry_t w_new;
    logic [15:0]  r_count;
    logic         w_in_hs;
    logic         w_out_hs;
    logic         w_load_out_new;
    logic         w_load_out_skid;
    logic         w_load_skid;
    logic [3:0]   w_dec_op;
    logic         w_dec_illegal;

    alu_op_decode u_decode (
        .alu_op    (alu_op),
        .funct     (funct),
        .operation (w_dec_op),
        .illegal   (w_dec_illegal)
    );

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;

    always_comb begin
        w_new.in1       = rs_val;
        w_new.in2       = alu_src ? imm : rt_val;
        w_new.operation = w_dec_op;
        w_new.illegal   = w_dec_illegal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_new  = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_hs) begin
                    w_state_nxt    = ST_ONE;
                    w_load_out_new = 1'b1;
                end
            end
            ST_ONE: begin
                // Simultaneous in/out bypasses the skid register entirely.
                if (w_in_hs && w_out_hs) begin
                    w_load_out_new = 1'b1;
                end else if (w_in_hs) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_hs) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_hs) begin
                    w_state_nxt     = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_skid  <= '0;
            r_count <= '0;
        end else begin
            if (w_load_out_new) begin
                r_out <= w_new;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_new;
            end
            if (w_out_hs) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign in1          = r_out.in1;
    assign in2          = r_out.in2;
    assign operation    = r_out.operation;
    assign illegal      = r_out.illegal;
    assign issued_count = r_count;

endmodule
